rom_load_unit: RTL and testbench

- Parametrised, clocked successor to the combinational byte ROM.
- Serves RISC-V style loads (LB/LH/LW/LBU/LHU) from a byte-organised ROM.
- Assembles one byte per access slot, with configurable wait states.
- Sits between the core's load/fetch path and program ROM. Returns a 32-bit extended result with a valid pulse, plus error flags for out-of-range addresses and unsupported widths.

---
 rtl/rom_load_pkg.sv | 36 +++
 rtl/rom_load_unit_if.sv | 21 ++
 rtl/rom_byte_array.sv | 22 ++
 rtl/rom_load_unit.sv | 144 ++++++++++++++
 tb/tb_rom_load_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_load_pkg.sv
// rtl/rom_load_pkg.sv - load encodings, FSM states and width/extension helpers
package rom_load_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_ERROR = 2'd2
   } state_e;

   // Zero marks an unsupported funct3.
   function automatic logic [2:0] load_bytes(input logic [2:0] f3);
      case (f3)
         F3_LB, F3_LBU: load_bytes = 3'd1;
         F3_LH, F3_LHU: load_bytes = 3'd2;
         F3_LW:         load_bytes = 3'd4;
         default:       load_bytes = 3'd0;
      endcase
   endfunction

   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
      case (f3)
         F3_LB:   extend_load = {{24{raw[7]}}, raw[7:0]};
         F3_LH:   extend_load = {{16{raw[15]}}, raw[15:0]};
         F3_LBU:  extend_load = {24'd0, raw[7:0]};
         F3_LHU:  extend_load = {16'd0, raw[15:0]};
         default: extend_load = raw;
      endcase
   endfunction

endpackage

// File: rtl/rom_load_unit_if.sv
// rtl/rom_load_unit_if.sv - load request/response bus between core and ROM unit
interface rom_load_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] address;
   logic [2:0]  funct3;
   logic        resp_valid;
   logic [31:0] read_data;
   logic        illegal_address;
   logic        illegal_width;

   modport master (
      output req_valid, address, funct3,
      input  req_ready, resp_valid, read_data, illegal_address, illegal_width
   );

   modport slave (
      input  req_valid, address, funct3,
      output req_ready, resp_valid, read_data, illegal_address, illegal_width
   );
endinterface

// File: rtl/rom_byte_array.sv
// rtl/rom_byte_array.sv - byte-organised ROM storage with a load port and async read
module rom_byte_array #(
   parameter  int DEPTH = 512,
   localparam int AW    = $clog2(4 * DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [4*DEPTH-1:0];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rom_load_unit.sv
// rtl/rom_load_unit.sv - byte-serial RISC-V load unit over a byte ROM
module rom_load_unit
   import rom_load_pkg::*;
#(
   parameter  int DEPTH       = 512,
   parameter  int WAIT_STATES = 0,
   localparam int AW          = $clog2(4 * DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   rom_load_unit_if.slave bus,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [7:0]    load_data
);

   localparam logic [32:0] ROM_BYTES = 33'(4 * DEPTH);

   state_e        state_q, state_d;
   logic [1:0]    byte_q, byte_d;
   logic [3:0]    wait_q, wait_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [2:0]    f3_q, f3_d;
   logic [31:0]   asm_q, asm_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          resp_q, resp_d;
   logic          ia_q, ia_d, iw_q, iw_d;
   logic          pend_ia_q, pend_ia_d, pend_iw_q, pend_iw_d;

   logic [2:0]    req_n, req_n_chk, cur_n;
   logic [32:0]   req_last;
   logic          req_bad_addr, req_bad_width;
   logic [AW-1:0] byte_addr;
   logic [7:0]    rd_data;

   // 33-bit sum so an address wrapping past 2^32-1 is flagged rather than aliased.
   assign req_n         = load_bytes(bus.funct3);
   assign req_bad_width = (req_n == 3'd0);
   assign req_n_chk     = req_bad_width ? 3'd1 : req_n;
   assign req_last      = {1'b0, bus.address} + {30'd0, req_n_chk} - 33'd1;
   assign req_bad_addr  = (req_last >= ROM_BYTES);
   assign cur_n         = load_bytes(f3_q);
   assign byte_addr     = addr_q + {{(AW-2){1'b0}}, byte_q};

   rom_byte_array #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .wr_en   (load_en),
      .wr_addr (load_addr),
      .wr_data (load_data),
      .rd_addr (byte_addr),
      .rd_data (rd_data)
   );

   assign bus.req_ready       = (state_q == ST_IDLE);
   assign bus.resp_valid      = resp_q;
   assign bus.read_data       = rdata_q;
   assign bus.illegal_address = ia_q;
   assign bus.illegal_width   = iw_q;

   always_comb begin
      state_d   = state_q;
      byte_d    = byte_q;
      wait_d    = wait_q;
      addr_d    = addr_q;
      f3_d      = f3_q;
      asm_d     = asm_q;
      rdata_d   = rdata_q;
      resp_d    = 1'b0;
      ia_d      = ia_q;
      iw_d      = iw_q;
      pend_ia_d = pend_ia_q;
      pend_iw_d = pend_iw_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               addr_d    = bus.address[AW-1:0];
               f3_d      = bus.funct3;
               byte_d    = 2'd0;
               wait_d    = 4'd0;
               asm_d     = '0;
               pend_ia_d = req_bad_addr;
               pend_iw_d = req_bad_width;
               state_d   = (req_bad_addr || req_bad_width) ? ST_ERROR : ST_READ;
            end
         end
         ST_READ: begin
            if (wait_q != 4'(WAIT_STATES)) begin
               wait_d = wait_q + 4'd1;
            end else begin
               wait_d = 4'd0;
               asm_d[{byte_q, 3'b000} +: 8] = rd_data;
               if ({1'b0, byte_q} == cur_n - 3'd1) begin
                  rdata_d = extend_load(f3_q, asm_d);
                  resp_d  = 1'b1;
                  ia_d    = 1'b0;
                  iw_d    = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  byte_d = byte_q + 2'd1;
               end
            end
         end
         ST_ERROR: begin
            rdata_d = '0;
            resp_d  = 1'b1;
            ia_d    = pend_ia_q;
            iw_d    = pend_iw_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         byte_q    <= '0;
         wait_q    <= '0;
         addr_q    <= '0;
         f3_q      <= '0;
         asm_q     <= '0;
         rdata_q   <= '0;
         resp_q    <= 1'b0;
         ia_q      <= 1'b0;
         iw_q      <= 1'b0;
         pend_ia_q <= 1'b0;
         pend_iw_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         byte_q    <= byte_d;
         wait_q    <= wait_d;
         addr_q    <= addr_d;
         f3_q      <= f3_d;
         asm_q     <= asm_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         ia_q      <= ia_d;
         iw_q      <= iw_d;
         pend_ia_q <= pend_ia_d;
         pend_iw_q <= pend_iw_d;
      end
   end

endmodule

// File: tb/tb_rom_load_unit.sv
// tb/tb_rom_load_unit.sv - randomized bench for rom_load_unit with 0 and 2 wait states
module tb_rom_load_unit;

   localparam int DEPTH = 512;
   localparam int NB    = 4 * DEPTH;
   localparam int AW    = $clog2(NB);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [7:0]    load_data = '0;
   logic          req_valid = 1'b0;
   logic [31:0]   address = '0;
   logic [2:0]    funct3 = '0;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] ref_mem [NB];

   always #5 clk = ~clk;

   rom_load_unit_if bus0 ();
   rom_load_unit_if bus2 ();

   assign bus0.req_valid = req_valid;
   assign bus0.address   = address;
   assign bus0.funct3    = funct3;
   assign bus2.req_valid = req_valid;
   assign bus2.address   = address;
   assign bus2.funct3    = funct3;

   rom_load_unit #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   rom_load_unit #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2.slave),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: little-endian byte sum, then sign fill from the top loaded bit.
   function automatic void model(input logic [31:0] a, input logic [2:0] f,
                                 output logic [31:0] data, output logic ia,
                                 output logic iw, output int n);
      bit sgn;
      longint unsigned last, val;
      case (f)
         3'd0: begin n = 1; sgn = 1; end
         3'd1: begin n = 2; sgn = 1; end
         3'd2: begin n = 4; sgn = 0; end
         3'd4: begin n = 1; sgn = 0; end
         3'd5: begin n = 2; sgn = 0; end
         default: begin n = 0; sgn = 0; end
      endcase
      iw   = (n == 0);
      last = {32'd0, a} + longint'((n == 0) ? 1 : n) - 1;
      ia   = (last >= longint'(NB));
      val  = 0;
      if (!ia && !iw) begin
         for (int i = 0; i < n; i++)
            val = val + (longint'(ref_mem[int'(a) + i]) << (8 * i));
         if (sgn && (((val >> (8 * n - 1)) & 1) == 1))
            val = val | ~((64'd1 << (8 * n)) - 1);
      end
      data = val[31:0];
   endfunction

   task automatic run_load(input logic [31:0] a, input logic [2:0] f, input string tag,
                           output logic [31:0] obs0);
      logic [31:0] ed;
      logic        eia, eiw;
      int          n, el0, el2;
      bit          got0, got2;
      model(a, f, ed, eia, eiw, n);
      el0 = (eia || eiw) ? 1 : n;
      el2 = (eia || eiw) ? 1 : 3 * n;
      obs0 = '0;
      @(negedge clk);
      check({tag, " ready0"}, bus0.req_ready, 1);
      check({tag, " ready2"}, bus2.req_ready, 1);
      req_valid = 1'b1;
      address   = a;
      funct3    = f;
      @(posedge clk);
      #1 req_valid = 1'b0;
      got0 = 0;
      got2 = 0;
      for (int c = 1; c <= 40 && !(got0 && got2); c++) begin
         @(posedge clk);
         #1;
         if (bus0.resp_valid) begin
            if (got0) check({tag, " dup0"}, 1, 0);
            else begin
               got0 = 1;
               obs0 = bus0.read_data;
               check({tag, " lat0"}, c, el0);
               check({tag, " data0"}, bus0.read_data, ed);
               check({tag, " iaddr0"}, bus0.illegal_address, eia);
               check({tag, " iwid0"}, bus0.illegal_width, eiw);
            end
         end
         if (bus2.resp_valid) begin
            if (got2) check({tag, " dup2"}, 1, 0);
            else begin
               got2 = 1;
               check({tag, " lat2"}, c, el2);
               check({tag, " data2"}, bus2.read_data, ed);
               check({tag, " iaddr2"}, bus2.illegal_address, eia);
               check({tag, " iwid2"}, bus2.illegal_width, eiw);
            end
         end
      end
      if (!got0) check({tag, " timeout0"}, 0, 1);
      if (!got2) check({tag, " timeout2"}, 0, 1);
   endtask

   task automatic back_to_back(input logic [31:0] a, input logic [2:0] f);
      logic [31:0] ed;
      logic        eia, eiw;
      int          n, l0, l2;
      bit          drained;
      model(a, f, ed, eia, eiw, n);
      l0 = n;
      l2 = 3 * n;
      @(negedge clk);
      req_valid = 1'b1;
      address   = a;
      funct3    = f;
      for (int e = 0; e < 30; e++) begin
         @(posedge clk);
         #1;
         check("b2b resp0", bus0.resp_valid, (e % (l0 + 1)) == l0);
         check("b2b resp2", bus2.resp_valid, (e % (l2 + 1)) == l2);
         if (bus0.resp_valid) check("b2b data0", bus0.read_data, ed);
         if (bus2.resp_valid) check("b2b data2", bus2.read_data, ed);
      end
      @(negedge clk);
      req_valid = 1'b0;
      drained = 0;
      for (int c = 0; c < 40 && !drained; c++) begin
         @(negedge clk);
         drained = bus0.req_ready && bus2.req_ready;
      end
      if (!drained) check("b2b drain", 0, 1);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, " resp0"}, bus0.resp_valid, 0);
      check({tag, " data0"}, bus0.read_data, 0);
      check({tag, " flags0"}, {bus0.illegal_address, bus0.illegal_width}, 0);
      check({tag, " ready0"}, bus0.req_ready, 1);
      check({tag, " resp2"}, bus2.resp_valid, 0);
      check({tag, " data2"}, bus2.read_data, 0);
      check({tag, " flags2"}, {bus2.illegal_address, bus2.illegal_width}, 0);
      check({tag, " ready2"}, bus2.req_ready, 1);
   endtask

   initial begin
      logic [31:0] obs, a;
      int          r;
      #1 reset = 1'b1;
      #2 check_cleared("reset");

      for (int i = 0; i < NB; i++) ref_mem[i] = 8'($urandom);
      ref_mem[16'h10] = 8'h78;
      ref_mem[16'h11] = 8'h56;
      ref_mem[16'h12] = 8'h34;
      ref_mem[16'h13] = 8'h12;
      ref_mem[16'h40] = 8'h80;
      ref_mem[16'h21] = 8'hFE;
      ref_mem[16'h22] = 8'hFF;
      for (int i = 0; i < NB; i++) begin
         @(negedge clk);
         load_en   = 1'b1;
         load_addr = AW'(i);
         load_data = ref_mem[i];
      end
      @(negedge clk);
      load_en = 1'b0;
      reset   = 1'b0;

      run_load(32'h10, 3'b010, "lw_0x10", obs);
      check("lw_0x10 const", obs, 32'h12345678);
      run_load(32'h40, 3'b000, "lb_0x40", obs);
      check("lb_0x40 const", obs, 32'hFFFFFF80);
      run_load(32'h40, 3'b100, "lbu_0x40", obs);
      check("lbu_0x40 const", obs, 32'h00000080);
      run_load(32'h21, 3'b001, "lh_0x21", obs);
      check("lh_0x21 const", obs, 32'hFFFFFFFE);
      run_load(32'h7FD, 3'b010, "lw_0x7fd", obs);
      check("lw_0x7fd const", obs, 32'h0);
      run_load(32'h7FC, 3'b010, "lw_0x7fc", obs);
      run_load(32'hFFFFFFFE, 3'b010, "lw_wrap", obs);
      run_load(32'h100, 3'b011, "f3_011", obs);
      run_load(32'h800, 3'b110, "f3_110", obs);
      run_load(32'h21, 3'b101, "lhu_0x21", obs);
      check("lhu_0x21 const", obs, 32'h0000FFFE);

      back_to_back(32'h21, 3'b001);

      run_load(32'h10, 3'b010, "pre_reset", obs);
      @(negedge clk);
      req_valid = 1'b1;
      address   = 32'h10;
      funct3    = 3'b010;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #1 check_cleared("mid_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         check("post_reset quiet0", bus0.resp_valid, 0);
         check("post_reset quiet2", bus2.resp_valid, 0);
      end
      run_load(32'h40, 3'b000, "lb_after_reset", obs);

      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         if (r < 7)      a = 32'($urandom_range(0, NB + 3));
         else if (r < 9) a = 32'(NB - 4 + $urandom_range(0, 3));
         else            a = $urandom;
         run_load(a, 3'($urandom_range(0, 7)), "rand", obs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
